// File: rtl/mul8u_err_pkg.sv
// Shared types, widths and saturating arithmetic for the mul8u error monitor.
package mul8u_err_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int PROD_W = 16;
  localparam int DIFF_W = 17;

  // Unsigned add clamped to 2^width-1; width may be anything from 1 to 64.
  function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                          input logic [63:0] inc,
                                          input int unsigned width);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, acc} + {1'b0, inc};
    lim = (65'd1 << width) - 65'd1;
    return (sum > lim) ? lim[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/mul8u_err_monitor_exact_ref.sv
// Exact 8x8 unsigned reference product used as the golden value in stage 1.
module mul8u_exact_ref
  import mul8u_err_pkg::*;
(
  input  logic [7:0]        a_i,
  input  logic [7:0]        b_i,
  output logic [PROD_W-1:0] prod_o
);

  assign prod_o = {8'b0, a_i} * {8'b0, b_i};

endmodule

// File: rtl/mul8u_err_monitor.sv
// Error-statistics monitor for an 8x8 approximate multiplier (3-cycle pipeline).
// Define MUL8U_ERR_WORST_CASE_EN to add the worst-case operand capture outputs.
module mul8u_err_monitor
  import mul8u_err_pkg::*;
#(
  parameter int unsigned N_SAMPLES = 256,
  parameter int unsigned SUM_W     = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [7:0]        a_i,
  input  logic [7:0]        b_i,
  input  logic [PROD_W-1:0] approx_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  sample_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [SUM_W-1:0]  sum_abs_err_o,
  output logic [PROD_W-1:0] max_abs_err_o
`ifdef MUL8U_ERR_WORST_CASE_EN
  ,
  output logic [7:0]        worst_a_o,
  output logic [7:0]        worst_b_o,
  output logic [PROD_W-1:0] worst_approx_o
`endif
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

  function automatic logic [PROD_W-1:0] abs_diff(input logic [PROD_W-1:0] exact,
                                                 input logic [PROD_W-1:0] approx);
    logic signed [DIFF_W-1:0] diff;
    diff = $signed({1'b0, exact}) - $signed({1'b0, approx});
    if (diff < 0) diff = -diff;
    return diff[PROD_W-1:0];
  endfunction

  function automatic logic [SUM_W-1:0] sat_sum(input logic [SUM_W-1:0]  acc,
                                               input logic [PROD_W-1:0] inc);
    return SUM_W'(sat_add(64'(acc), 64'(inc), SUM_W));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] acc);
    return CNT_W'(sat_add(64'(acc), 64'd1, CNT_W));
  endfunction

  state_e              state_q;
  logic                ready_q, busy_q, done_q;
  logic [CNT_W-1:0]    sample_cnt_q, err_cnt_q, err_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [PROD_W-1:0]   max_q, max_d;
  logic                max_upd;
  logic                accept;

  logic [PROD_W-1:0]   exact_w, absdiff_w;
  logic [PROD_W-1:0]   exact_p1, approx_p1;
  logic                vld_p1;
  logic [PROD_W-1:0]   absdiff_p2;
  logic                mismatch_p2;
  logic                vld_p2;

  // Dropped samples while not ready; a clear wins over acceptance.
  assign accept = valid_i & ready_q & ~clear_i;

  mul8u_exact_ref u_exact (
    .a_i    (a_i),
    .b_i    (b_i),
    .prod_o (exact_w)
  );

  assign absdiff_w = abs_diff(exact_p1, approx_p1);

  // Stage 1 captures exact/approx; stage 2 captures |exact - approx|.
  always_ff @(posedge clk) begin
    exact_p1    <= exact_w;
    approx_p1   <= approx_i;
    absdiff_p2  <= absdiff_w;
    mismatch_p2 <= (absdiff_w != '0);
  end

`ifdef MUL8U_ERR_WORST_CASE_EN
  logic [7:0]        a_p1, b_p1, a_p2, b_p2;
  logic [PROD_W-1:0] approx_p2;
  logic [7:0]        worst_a_q, worst_b_q;
  logic [PROD_W-1:0] worst_approx_q;

  always_ff @(posedge clk) begin
    a_p1      <= a_i;
    b_p1      <= b_i;
    a_p2      <= a_p1;
    b_p2      <= b_p1;
    approx_p2 <= approx_p1;
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i || ((state_q == IDLE || state_q == DONE) && start_i)) begin
      worst_a_q      <= '0;
      worst_b_q      <= '0;
      worst_approx_q <= '0;
    end else if (max_upd) begin
      worst_a_q      <= a_p2;
      worst_b_q      <= b_p2;
      worst_approx_q <= approx_p2;
    end
  end

  assign worst_a_o      = worst_a_q;
  assign worst_b_o      = worst_b_q;
  assign worst_approx_o = worst_approx_q;
`endif

  // Stage 3 folds the stage-2 result into the running statistics.
  always_comb begin
    err_d   = err_cnt_q;
    sum_d   = sum_q;
    max_d   = max_q;
    max_upd = 1'b0;
    if (vld_p2) begin
      if (mismatch_p2) err_d = sat_inc(err_cnt_q);
      sum_d = sat_sum(sum_q, absdiff_p2);
      if (absdiff_p2 > max_q) begin
        max_d   = absdiff_p2;
        max_upd = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      vld_p1       <= 1'b0;
      vld_p2       <= 1'b0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      sum_q        <= '0;
      max_q        <= '0;
    end else begin
      vld_p1    <= accept;
      vld_p2    <= vld_p1;
      err_cnt_q <= err_d;
      sum_q     <= sum_d;
      max_q     <= max_d;
      if (accept) sample_cnt_q <= sample_cnt_q + CNT_W'(1);
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q      <= RUN;
            ready_q      <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sum_q        <= '0;
            max_q        <= '0;
          end
        end
        RUN: begin
          if (accept && sample_cnt_q == LAST_IDX) begin
            state_q <= DRAIN;
            ready_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (!vld_p1 && !vld_p2) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o       = ready_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign sample_cnt_o  = sample_cnt_q;
  assign err_cnt_o     = err_cnt_q;
  assign sum_abs_err_o = sum_q;
  assign max_abs_err_o = max_q;

endmodule

// File: tb/tb_mul8u_err_monitor.sv
// Scoreboard bench for mul8u_err_monitor: DUT A (N=2, SUM_W=32) and DUT B (N=4, SUM_W=17).
module tb_mul8u_err_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, clear, valid, sel;
  logic [7:0]  a, b;
  logic [15:0] approx;

  logic        rdy_a, busy_a, done_a, rdy_b, busy_b, done_b;
  logic [15:0] scnt_a, ecnt_a, max_a, scnt_b, ecnt_b, max_b;
  logic [31:0] sum_a;
  logic [16:0] sum_b;

  logic        rdy, busy, done;
  logic [15:0] scnt, ecnt, mx;
  logic [31:0] sum;

`ifdef MUL8U_ERR_WORST_CASE_EN
  logic [7:0]  wa_a, wb_a, wa_b, wb_b, wa, wb;
  logic [15:0] wap_a, wap_b, wap;
`endif

  mul8u_err_monitor #(.N_SAMPLES(2), .SUM_W(32), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .start_i(start & ~sel), .clear_i(clear), .valid_i(valid),
    .ready_o(rdy_a), .a_i(a), .b_i(b), .approx_i(approx), .busy_o(busy_a), .done_o(done_a),
    .sample_cnt_o(scnt_a), .err_cnt_o(ecnt_a), .sum_abs_err_o(sum_a), .max_abs_err_o(max_a)
`ifdef MUL8U_ERR_WORST_CASE_EN
    , .worst_a_o(wa_a), .worst_b_o(wb_a), .worst_approx_o(wap_a)
`endif
  );

  mul8u_err_monitor #(.N_SAMPLES(4), .SUM_W(17), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .start_i(start & sel), .clear_i(clear), .valid_i(valid),
    .ready_o(rdy_b), .a_i(a), .b_i(b), .approx_i(approx), .busy_o(busy_b), .done_o(done_b),
    .sample_cnt_o(scnt_b), .err_cnt_o(ecnt_b), .sum_abs_err_o(sum_b), .max_abs_err_o(max_b)
`ifdef MUL8U_ERR_WORST_CASE_EN
    , .worst_a_o(wa_b), .worst_b_o(wb_b), .worst_approx_o(wap_b)
`endif
  );

  always_comb begin
    rdy  = sel ? rdy_b  : rdy_a;
    busy = sel ? busy_b : busy_a;
    done = sel ? done_b : done_a;
    scnt = sel ? scnt_b : scnt_a;
    ecnt = sel ? ecnt_b : ecnt_a;
    mx   = sel ? max_b  : max_a;
    sum  = sel ? {15'b0, sum_b} : sum_a;
`ifdef MUL8U_ERR_WORST_CASE_EN
    wa   = sel ? wa_b  : wa_a;
    wb   = sel ? wb_b  : wb_a;
    wap  = sel ? wap_b : wap_a;
`endif
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] cnt;
    logic [15:0] err;
    logic [63:0] sum;
    logic [15:0] mx;
    logic [7:0]  wa;
    logic [7:0]  wb;
    logic [15:0] wap;
    int          due;
  } sb_t;

  sb_t exp_q[$];
  sb_t pend_q[$];

  logic [15:0] m_cnt, m_err, m_max, m_wap;
  logic [63:0] m_sum, m_lim;
  logic [7:0]  m_wa, m_wb;

  task automatic model_reset();
    m_cnt = '0; m_err = '0; m_max = '0; m_sum = '0;
    m_wa = '0; m_wb = '0; m_wap = '0;
    m_lim = sel ? 64'h1FFFF : 64'hFFFF_FFFF;
  endtask

  task automatic push_exp(input logic [7:0] ea, input logic [7:0] eb, input logic [15:0] eap);
    int  ex, d;
    sb_t e;
    ex = int'(ea) * int'(eb);
    d  = ex - int'(eap);
    if (d < 0) d = -d;
    m_cnt++;
    if (d != 0 && m_err != 16'hFFFF) m_err++;
    m_sum = m_sum + 64'(d);
    if (m_sum > m_lim) m_sum = m_lim;
    if (d > int'(m_max)) begin
      m_max = 16'(d); m_wa = ea; m_wb = eb; m_wap = eap;
    end
    e.cnt = m_cnt; e.err = m_err; e.sum = m_sum; e.mx = m_max;
    e.wa = m_wa; e.wb = m_wb; e.wap = m_wap; e.due = 0;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] sa, input logic [7:0] sb, input logic [15:0] sap);
    push_exp(sa, sb, sap);
    valid = 1'b1; a = sa; b = sb; approx = sap;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  int edge_cnt = 0;

  always @(posedge clk) begin : mon
    sb_t e;
    edge_cnt = edge_cnt + 1;
    if (rst || clear) pend_q.delete();
    else if (valid && rdy) begin
      if (exp_q.size() == 0) check_eq("spurious_accept", 1, 0);
      else begin
        e = exp_q.pop_front();
        e.due = edge_cnt;
        pend_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (pend_q.size() > 0 && pend_q[$].due == edge_cnt)
      check_eq("sample_cnt_at_accept", 64'(scnt), 64'(pend_q[$].cnt));
    while (pend_q.size() > 0 && pend_q[0].due + 2 == edge_cnt) begin
      check_eq("err_cnt_t3", 64'(ecnt), 64'(pend_q[0].err));
      check_eq("sum_t3", 64'(sum), pend_q[0].sum);
      check_eq("max_t3", 64'(mx), 64'(pend_q[0].mx));
`ifdef MUL8U_ERR_WORST_CASE_EN
      check_eq("worst_a_t3", 64'(wa), 64'(pend_q[0].wa));
      check_eq("worst_b_t3", 64'(wb), 64'(pend_q[0].wb));
      check_eq("worst_approx_t3", 64'(wap), 64'(pend_q[0].wap));
`endif
      void'(pend_q.pop_front());
    end
  end

  task automatic start_run();
    model_reset();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_after_start", 64'(busy), 1);
    check_eq("ready_after_start", 64'(rdy), 1);
    check_eq("sum_zero_after_start", 64'(sum), 0);
    check_eq("max_zero_after_start", 64'(mx), 0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq(tag, 64'(done), 1);
    check_eq("busy_at_done", 64'(busy), 0);
    check_eq("ready_at_done", 64'(rdy), 0);
  endtask

  task automatic final_check(input string tag);
    check_eq({tag, "_cnt"}, 64'(scnt), 64'(m_cnt));
    check_eq({tag, "_err"}, 64'(ecnt), 64'(m_err));
    check_eq({tag, "_sum"}, 64'(sum), m_sum);
    check_eq({tag, "_max"}, 64'(mx), 64'(m_max));
`ifdef MUL8U_ERR_WORST_CASE_EN
    check_eq({tag, "_worst_a"}, 64'(wa), 64'(m_wa));
    check_eq({tag, "_worst_b"}, 64'(wb), 64'(m_wb));
    check_eq({tag, "_worst_ap"}, 64'(wap), 64'(m_wap));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "global timeout");
  end

  logic [15:0] hs_ap[5];

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; valid = 1'b0; sel = 1'b0;
    a = '0; b = '0; approx = '0;
    hs_ap[0] = 16'd1; hs_ap[1] = 16'd5; hs_ap[2] = 16'd9; hs_ap[3] = 16'd16; hs_ap[4] = 16'd25;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_eq("rst_busy", 64'(busy), 0);
    check_eq("rst_done", 64'(done), 0);
    check_eq("rst_ready", 64'(rdy), 0);
    check_eq("rst_sample_cnt", 64'(scnt), 0);
    check_eq("rst_err_cnt", 64'(ecnt), 0);
    check_eq("rst_sum", 64'(sum), 0);
    check_eq("rst_max", 64'(mx), 0);

    // Exact match on DUT B (N=4)
    sel = 1'b1;
    start_run();
    send(8'd3, 8'd5, 16'd15);
    send(8'd0, 8'd255, 16'd0);
    send(8'd255, 8'd255, 16'd65025);
    send(8'd16, 8'd16, 16'd256);
    wait_done("exact_done");
    final_check("exact");

    // Saturation on DUT B (SUM_W=17)
    start_run();
    repeat (4) send(8'd255, 8'd255, 16'd0);
    wait_done("sat_done");
    final_check("sat");
    check_eq("sat_sum_value", 64'(sum), 131071);

    // Error accumulation on DUT A (N=2)
    sel = 1'b0;
    start_run();
    send(8'd3, 8'd5, 16'd20);
    send(8'd10, 8'd10, 16'd96);
    wait_done("accum_done");
    final_check("accum");

    // Worst case
    start_run();
    send(8'd255, 8'd255, 16'd0);
    send(8'd2, 8'd2, 16'd0);
    wait_done("worst_done");
    final_check("worst");
    check_eq("worst_max_value", 64'(mx), 65025);

    // Handshake: valid held high for 5 cycles, only 2 may be accepted
    start_run();
    push_exp(8'd1, 8'd1, hs_ap[0]);
    push_exp(8'd2, 8'd2, hs_ap[1]);
    for (int j = 0; j < 5; j++) begin
      valid = 1'b1; a = 8'(j + 1); b = 8'(j + 1); approx = hs_ap[j];
      check_eq("hs_ready", 64'(rdy), (j < 2) ? 64'd1 : 64'd0);
      @(posedge clk); #1;
    end
    valid = 1'b0;
    wait_done("hs_done");
    final_check("hs");

    // Abort with a sample in flight
    start_run();
    send(8'd7, 8'd7, 16'd0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_reset();
    for (int j = 0; j < 4; j++) begin
      check_eq("abort_err", 64'(ecnt), 0);
      check_eq("abort_sum", 64'(sum), 0);
      check_eq("abort_max", 64'(mx), 0);
      @(posedge clk); #1;
    end
    check_eq("abort_cnt", 64'(scnt), 0);
    check_eq("abort_busy", 64'(busy), 0);
    check_eq("abort_done", 64'(done), 0);
    check_eq("abort_ready", 64'(rdy), 0);
    start_run();
    send(8'd9, 8'd9, 16'd80);
    send(8'd1, 8'd2, 16'd2);
    wait_done("post_abort_done");
    final_check("post_abort");

    repeat (3) @(posedge clk);
    check_eq("exp_queue_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
